// File: rtl/conv_result_buffer.sv
// Capture buffer for one 8x10 convolution result frame: validates the upstream
// stream, stores it in a synchronous RAM, tracks the maximum and lets a user browse entries.
module conv_result_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        in_valid,
  input  logic [11:0] in_elem,
  input  logic        in_row_end,
  input  logic        in_last,
  input  logic [3:0]  in_row_idx,
  input  logic [3:0]  in_col_idx,
  input  logic        step_next,
  input  logic        step_prev,
  output logic [1:0]  state_o,
  output logic [6:0]  count,
  output logic [1:0]  err_code,
  output logic [3:0]  sel_row,
  output logic [3:0]  sel_col,
  output logic [11:0] disp_elem,
  output logic        disp_valid,
  output logic [11:0] max_elem,
  output logic [3:0]  max_row,
  output logic [3:0]  max_col
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_READY   = 2'b10,
    S_ERROR   = 2'b11
  } state_t;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_INDEX   = 2'b01;
  localparam logic [1:0] E_STROBE  = 2'b10;
  localparam logic [1:0] E_OVERRUN = 2'b11;

  state_t      r_state;
  logic [6:0]  r_wr_ptr;
  logic [6:0]  r_count;
  logic [1:0]  r_err;
  logic [11:0] r_max_elem;
  logic [3:0]  r_max_row;
  logic [3:0]  r_max_col;
  logic [3:0]  r_sel_row;
  logic [3:0]  r_sel_col;
  logic        r_rd_req;
  logic        r_disp_valid;
  logic [11:0] r_disp_elem;
  logic [11:0] r_mem [0:79];

  logic [7:0]  w_in_idx;
  logic        w_idx_ok;
  logic        w_ptr_last;
  logic        w_strobe_ok;
  logic        w_accept;
  logic        w_step;
  logic [6:0]  w_sel_addr;
  logic [3:0]  w_next_row;
  logic [3:0]  w_next_col;

  assign w_in_idx    = ({4'd0, in_row_idx} * 8'd10) + {4'd0, in_col_idx};
  assign w_idx_ok    = (w_in_idx == {1'b0, r_wr_ptr});
  assign w_ptr_last  = (r_wr_ptr == 7'd79);
  assign w_strobe_ok = (in_row_end == (in_col_idx == 4'd9)) && (in_last == w_ptr_last);
  assign w_accept    = !rst && !arm && (r_state == S_CAPTURE) && in_valid && w_idx_ok && w_strobe_ok;
  assign w_step      = step_next ^ step_prev;
  assign w_sel_addr  = ({3'd0, r_sel_row} * 7'd10) + {3'd0, r_sel_col};

  // Row-major neighbour of the current browse position, wrapping at the frame ends.
  always_comb begin
    w_next_row = r_sel_row;
    w_next_col = r_sel_col;
    if (step_next) begin
      if (r_sel_col == 4'd9) begin
        w_next_col = 4'd0;
        w_next_row = (r_sel_row == 4'd7) ? 4'd0 : r_sel_row + 4'd1;
      end else begin
        w_next_col = r_sel_col + 4'd1;
      end
    end else begin
      if (r_sel_col == 4'd0) begin
        w_next_col = 4'd9;
        w_next_row = (r_sel_row == 4'd0) ? 4'd7 : r_sel_row - 4'd1;
      end else begin
        w_next_col = r_sel_col - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= 7'd0;
      r_count      <= 7'd0;
      r_err        <= E_NONE;
      r_max_elem   <= 12'd0;
      r_max_row    <= 4'd0;
      r_max_col    <= 4'd0;
      r_sel_row    <= 4'd0;
      r_sel_col    <= 4'd0;
      r_rd_req     <= 1'b0;
      r_disp_valid <= 1'b0;
    end else if (arm) begin
      // arm restarts capture from any state and drops any coincident element
      r_state      <= S_CAPTURE;
      r_wr_ptr     <= 7'd0;
      r_count      <= 7'd0;
      r_err        <= E_NONE;
      r_max_elem   <= 12'd0;
      r_max_row    <= 4'd0;
      r_max_col    <= 4'd0;
      r_sel_row    <= 4'd0;
      r_sel_col    <= 4'd0;
      r_rd_req     <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          if (in_valid) begin
            if (!w_idx_ok) begin
              r_state <= S_ERROR;
              r_err   <= E_INDEX;
            end else if (!w_strobe_ok) begin
              r_state <= S_ERROR;
              r_err   <= E_STROBE;
            end else begin
              r_wr_ptr <= r_wr_ptr + 7'd1;
              r_count  <= r_count + 7'd1;
              // Strict compare keeps the first of equal maxima
              if ((r_count == 7'd0) || (in_elem > r_max_elem)) begin
                r_max_elem <= in_elem;
                r_max_row  <= in_row_idx;
                r_max_col  <= in_col_idx;
              end
              if (w_ptr_last) begin
                r_state   <= S_READY;
                r_sel_row <= 4'd0;
                r_sel_col <= 4'd0;
                r_rd_req  <= 1'b1;
              end
            end
          end
        end
        S_READY: begin
          if (in_valid) begin
            r_state      <= S_ERROR;
            r_err        <= E_OVERRUN;
            r_rd_req     <= 1'b0;
            r_disp_valid <= 1'b0;
          end else if (w_step) begin
            r_sel_row    <= w_next_row;
            r_sel_col    <= w_next_col;
            r_rd_req     <= 1'b1;
            r_disp_valid <= 1'b0;
          end else if (r_rd_req) begin
            r_rd_req     <= 1'b0;
            r_disp_valid <= 1'b1;
          end
        end
        default: begin
          r_rd_req     <= 1'b0;
          r_disp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage; contents survive arm and reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_elem;
    end
  end

  // Registered read port feeding the display output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_elem <= 12'd0;
    end else if (!arm && r_rd_req && (r_state == S_READY)) begin
      r_disp_elem <= r_mem[w_sel_addr];
    end
  end

  assign state_o    = r_state;
  assign count      = r_count;
  assign err_code   = r_err;
  assign sel_row    = r_sel_row;
  assign sel_col    = r_sel_col;
  assign disp_elem  = r_disp_elem;
  assign disp_valid = r_disp_valid;
  assign max_elem   = r_max_elem;
  assign max_row    = r_max_row;
  assign max_col    = r_max_col;

endmodule

// File: tb/tb_conv_result_buffer.sv
// Directed bench for conv_result_buffer with a scoreboard queue of expected display entries.
module tb_conv_result_buffer;

  logic        clk = 1'b0;
  logic        rst, arm, in_valid, in_row_end, in_last, step_next, step_prev;
  logic [11:0] in_elem;
  logic [3:0]  in_row_idx, in_col_idx;
  logic [1:0]  state_o, err_code;
  logic [6:0]  count;
  logic [3:0]  sel_row, sel_col, max_row, max_col;
  logic [11:0] disp_elem, max_elem;
  logic        disp_valid;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic [11:0] mv [0:79];
  logic [19:0] sb_q [$];

  conv_result_buffer dut (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_elem(in_elem),
    .in_row_end(in_row_end), .in_last(in_last), .in_row_idx(in_row_idx),
    .in_col_idx(in_col_idx), .step_next(step_next), .step_prev(step_prev),
    .state_o(state_o), .count(count), .err_code(err_code), .sel_row(sel_row),
    .sel_col(sel_col), .disp_elem(disp_elem), .disp_valid(disp_valid),
    .max_elem(max_elem), .max_row(max_row), .max_col(max_col)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [19:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, {12'd0, sel_row, sel_col, disp_elem}, {12'd0, e});
    end
  endtask

  task automatic wait_disp(input string tag);
    int n = 0;
    while (!disp_valid && n < 6) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, disp_valid}, 32'd1);
    if (disp_valid) pop_cmp(tag);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int r, input int c, input logic [11:0] e, input logic re, input logic la);
    in_valid   = 1'b1;
    in_row_idx = 4'(r);
    in_col_idx = 4'(c);
    in_elem    = e;
    in_row_end = re;
    in_last    = la;
    tick();
    in_valid   = 1'b0;
    in_row_end = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++)
      send(i / 10, i % 10, mv[i], (i % 10) == 9, i == 79);
  endtask

  task automatic step(input logic n, input logic p);
    if (n && !p) pos = (pos + 1) % 80;
    else if (p && !n) pos = (pos + 79) % 80;
    sb_q.push_back({4'(pos / 10), 4'(pos % 10), mv[pos]});
    step_next = n;
    step_prev = p;
    tick();
    step_next = 1'b0;
    step_prev = 1'b0;
    chk("step_drop", {31'd0, disp_valid}, 32'd0);
    tick();
    chk("step_valid", {31'd0, disp_valid}, 32'd1);
    pop_cmp("step_disp");
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; in_row_end = 1'b0; in_last = 1'b0;
    step_next = 1'b0; step_prev = 1'b0; in_elem = 12'd0; in_row_idx = 4'd0; in_col_idx = 4'd0;
    for (int i = 0; i < 80; i++) mv[i] = 12'(i % 729);
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_disp", {19'd0, disp_valid, disp_elem}, 32'd0);
    chk("rst_max", {12'd0, max_elem, max_row, max_col}, 32'd0);

    // Full frame and browse
    pulse_arm();
    chk("arm_state", {30'd0, state_o}, 32'd1);
    step_next = 1'b1; tick(); step_next = 1'b0;
    chk("step_in_capture", {24'd0, sel_row, sel_col}, 32'd0);
    send_frame(80);
    chk("full_state", {30'd0, state_o}, 32'd2);
    chk("full_count", {25'd0, count}, 32'd80);
    chk("full_max", {12'd0, max_elem, max_row, max_col}, {12'd0, 12'd79, 4'd7, 4'd9});
    chk("ready_disp_low", {31'd0, disp_valid}, 32'd0);
    pos = 0;
    sb_q.push_back({4'd0, 4'd0, mv[0]});
    wait_disp("ready_disp");
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step_next = 1'b1; step_prev = 1'b1; tick(); step_next = 1'b0; step_prev = 1'b0;
    chk("both_steps", {19'd0, disp_valid, sel_row, sel_col}, {19'd0, 1'b1, 4'd0, 4'd1});
    chk("both_elem", {20'd0, disp_elem}, 32'd1);

    // Overrun
    send(0, 0, 12'd5, 1'b0, 1'b0);
    chk("ovr_state", {28'd0, state_o, err_code}, {28'd0, 2'b11, 2'b11});
    chk("ovr_disp", {31'd0, disp_valid}, 32'd0);

    // Index fault at element 25
    pulse_arm();
    send_frame(25);
    send(2, 6, 12'd26, 1'b0, 1'b0);
    chk("idx_err", {28'd0, state_o, err_code}, {28'd0, 2'b11, 2'b01});
    chk("idx_count", {25'd0, count}, 32'd25);
    send(2, 5, 12'd25, 1'b0, 1'b0);
    chk("err_ignore", {25'd0, count}, 32'd25);

    // Strobe fault: row_end missing at col 9
    pulse_arm();
    send_frame(9);
    send(0, 9, mv[9], 1'b0, 1'b0);
    chk("strobe_err", {28'd0, state_o, err_code}, {28'd0, 2'b11, 2'b10});
    chk("strobe_count", {25'd0, count}, 32'd9);

    // Tie for maximum, then browse to the first occurrence
    mv[23] = 12'd729;
    mv[61] = 12'd729;
    pulse_arm();
    send_frame(80);
    chk("tie_max", {12'd0, max_elem, max_row, max_col}, {12'd0, 12'd729, 4'd2, 4'd3});
    pos = 0;
    sb_q.push_back({4'd0, 4'd0, mv[0]});
    wait_disp("tie_disp0");
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0);

    // Reset mid-capture overrides arm
    pulse_arm();
    send_frame(40);
    chk("cap40_count", {25'd0, count}, 32'd40);
    rst = 1'b1; arm = 1'b1;
    tick();
    rst = 1'b0; arm = 1'b0;
    chk("mid_rst_state", {26'd0, state_o, count[3:0]}, 32'd0);
    chk("mid_rst_count", {25'd0, count}, 32'd0);
    chk("mid_rst_outs", {6'd0, err_code, sel_row, sel_col, disp_valid, disp_elem}, 32'd0);
    chk("mid_rst_max", {12'd0, max_elem, max_row, max_col}, 32'd0);
    send(0, 0, 12'd1, 1'b0, 1'b0);
    chk("idle_ignore", {25'd0, count}, 32'd0);

    // arm coincident with in_valid
    pulse_arm();
    send_frame(5);
    arm = 1'b1;
    send(0, 5, mv[5], 1'b0, 1'b0);
    arm = 1'b0;
    chk("arm_vs_valid", {23'd0, state_o, err_code, count}, {23'd0, 2'b01, 2'b00, 7'd0});
    send(0, 0, mv[0], 1'b0, 1'b0);
    chk("arm_restart", {25'd0, count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
